// File: rtl/scalar_mult_ctrl.sv
// Scalar multiplier sequencer: Q = k*P by MSB-first double-and-add over an external point-add unit.
// Latency: 1 init op + one double per bit below the MSB + one add per set bit below the MSB, plus about 1 cycle per leading zero and per bit.
// Backpressure: one point-add op in flight at a time; each op waits for i_pa_finished, and i_start is ignored while busy.
module scalar_mult_ctrl #(
    parameter logic [254:0] ONE_MONT = 255'd19,
    parameter int           IDX_W    = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_scalar,
    input  logic [254:0] i_x,
    input  logic [254:0] i_y,
    output logic         o_busy,
    output logic         o_done,
    output logic [254:0] o_x,
    output logic [254:0] o_y,
    output logic [254:0] o_z,
    output logic [254:0] o_t,
    output logic         o_pa_start,
    output logic         o_pa_doubling,
    output logic         o_pa_initial,
    output logic [254:0] o_pa_x1,
    output logic [254:0] o_pa_y1,
    output logic [254:0] o_pa_z1,
    output logic [254:0] o_pa_t1,
    output logic [254:0] o_pa_x2,
    output logic [254:0] o_pa_y2,
    output logic [254:0] o_pa_z2,
    output logic [254:0] o_pa_t2,
    input  logic [254:0] i_pa_x3,
    input  logic [254:0] i_pa_y3,
    input  logic [254:0] i_pa_z3,
    input  logic [254:0] i_pa_t3,
    input  logic         i_pa_finished
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_INIT_W = 4'd2;
    localparam logic [3:0] S_SCAN   = 4'd3;
    localparam logic [3:0] S_DBL    = 4'd4;
    localparam logic [3:0] S_DBL_W  = 4'd5;
    localparam logic [3:0] S_ADD    = 4'd6;
    localparam logic [3:0] S_ADD_W  = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(254);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [3:0]       state;
    logic [254:0]     k_reg;
    logic [254:0]     base_x, base_y;
    logic [254:0]     p_x, p_y, p_z, p_t;
    logic [254:0]     q_x, q_y, q_z, q_t;
    logic [IDX_W-1:0] idx;
    logic             k_bit;

    // Scalar bit currently being processed.
    assign k_bit = k_reg[idx];

    // Main sequencer. Operands and op-select flags are written only when an op
    // is launched, so they hold steady until the point-add unit finishes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            k_reg         <= '0;
            base_x        <= '0;
            base_y        <= '0;
            p_x           <= '0;
            p_y           <= '0;
            p_z           <= '0;
            p_t           <= '0;
            q_x           <= '0;
            q_y           <= '0;
            q_z           <= '0;
            q_t           <= '0;
            idx           <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_z           <= '0;
            o_t           <= '0;
            o_pa_start    <= 1'b0;
            o_pa_doubling <= 1'b0;
            o_pa_initial  <= 1'b0;
            o_pa_x1       <= '0;
            o_pa_y1       <= '0;
            o_pa_z1       <= '0;
            o_pa_t1       <= '0;
            o_pa_x2       <= '0;
            o_pa_y2       <= '0;
            o_pa_z2       <= '0;
            o_pa_t2       <= '0;
        end else begin
            o_pa_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        k_reg  <= i_scalar;
                        base_x <= i_x;
                        base_y <= i_y;
                        idx    <= IDX_TOP;
                        o_busy <= 1'b1;
                        state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b1;
                    o_pa_doubling <= 1'b0;
                    o_pa_x1       <= base_x;
                    o_pa_y1       <= base_y;
                    o_pa_z1       <= '0;
                    o_pa_t1       <= '0;
                    o_pa_x2       <= '0;
                    o_pa_y2       <= '0;
                    o_pa_z2       <= '0;
                    o_pa_t2       <= '0;
                    state         <= S_INIT_W;
                end
                S_INIT_W: begin
                    if (i_pa_finished) begin
                        p_x   <= i_pa_x3;
                        p_y   <= i_pa_y3;
                        p_z   <= i_pa_z3;
                        p_t   <= i_pa_t3;
                        state <= S_SCAN;
                    end
                end
                // Skip leading zeros; the first set bit seeds Q with P.
                S_SCAN: begin
                    if (k_bit) begin
                        q_x <= p_x;
                        q_y <= p_y;
                        q_z <= p_z;
                        q_t <= p_t;
                        if (idx == IDX_ZERO) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx - IDX_ONE;
                            state <= S_DBL;
                        end
                    end else if (idx == IDX_ZERO) begin
                        q_x   <= '0;
                        q_y   <= ONE_MONT;
                        q_z   <= ONE_MONT;
                        q_t   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx - IDX_ONE;
                    end
                end
                S_DBL: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b0;
                    o_pa_doubling <= 1'b1;
                    o_pa_x1       <= q_x;
                    o_pa_y1       <= q_y;
                    o_pa_z1       <= q_z;
                    o_pa_t1       <= q_t;
                    o_pa_x2       <= q_x;
                    o_pa_y2       <= q_y;
                    o_pa_z2       <= q_z;
                    o_pa_t2       <= q_t;
                    state         <= S_DBL_W;
                end
                S_DBL_W: begin
                    if (i_pa_finished) begin
                        q_x   <= i_pa_x3;
                        q_y   <= i_pa_y3;
                        q_z   <= i_pa_z3;
                        q_t   <= i_pa_t3;
                        state <= k_bit ? S_ADD : S_NEXT;
                    end
                end
                S_ADD: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b0;
                    o_pa_doubling <= 1'b0;
                    o_pa_x1       <= q_x;
                    o_pa_y1       <= q_y;
                    o_pa_z1       <= q_z;
                    o_pa_t1       <= q_t;
                    o_pa_x2       <= p_x;
                    o_pa_y2       <= p_y;
                    o_pa_z2       <= p_z;
                    o_pa_t2       <= p_t;
                    state         <= S_ADD_W;
                end
                S_ADD_W: begin
                    if (i_pa_finished) begin
                        q_x   <= i_pa_x3;
                        q_y   <= i_pa_y3;
                        q_z   <= i_pa_z3;
                        q_t   <= i_pa_t3;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == IDX_ZERO) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx - IDX_ONE;
                        state <= S_DBL;
                    end
                end
                // Result registers, done pulse and busy release all land on the same edge.
                S_DONE: begin
                    o_x    <= q_x;
                    o_y    <= q_y;
                    o_z    <= q_z;
                    o_t    <= q_t;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Sequences the shared extended-coordinate point-add/double unit to compute Q = k·P on Curve25519/Ed25519 using MSB-first double-and-add.
- Accepts an affine base point and a 255-bit scalar.
- Issues an initial Montgomery-domain conversion, then one double per scalar bit and one add per set bit.
- Returns the extended result (X, Y, Z, T) in the Montgomery domain; it sits between the top-level signature/keygen FSM and the point-add unit.

Parameters:
- ONE_MONT, 255'd19, Montgomery form of 1 (2^255 mod p), used for the identity point.
- IDX_W, 8, width of the bit-index counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_start  in  1  start request; sampled only in S_IDLE
- i_scalar  in  255  scalar k
- i_x  in  255  affine base x (normal domain)
- i_y  in  255  affine base y (normal domain)
- o_busy  out  1  high from the cycle after accepted start until o_done
- o_done  out  1  one-cycle pulse, result valid
- o_x, o_y, o_z, o_t  out  255 each  result Q, held until next accepted start
- o_pa_start  out  1  one-cycle start pulse to the point-add unit
- o_pa_doubling  out  1  operation select: double
- o_pa_initial  out  1  operation select: affine-to-Montgomery conversion
- o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1  out  255 each  operand 1
- o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2  out  255 each  operand 2
- i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3  in  255 each  point-add result
- i_pa_finished  in  1  point-add completion pulse

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
  - Reset drives all registers to 0 and the state to S_IDLE.
  - o_busy=0, o_done=0, o_pa_start=0, all data outputs 0.
  - The point-add unit shares this reset, so reset mid-operation aborts cleanly: no o_done, results zeroed.
- Registers: scalar K, base point P(4×255), accumulator Q(4×255), index idx (IDX_W bits).
- States: S_IDLE, S_INIT, S_INIT_W, S_SCAN, S_DBL, S_DBL_W, S_ADD, S_ADD_W, S_NEXT, S_DONE.
- S_IDLE:
  - On i_start: latch K, i_x, i_y; idx=254; go S_INIT.
  - i_start in any other state is ignored.
- S_INIT:
  - Pulse o_pa_start with o_pa_initial=1, o_pa_doubling=0.
  - Operand 1 = (i_x latched, i_y latched, 0, 0); operand 2 = 0.
  - Go S_INIT_W.
- S_INIT_W:
  - On i_pa_finished: P = (x3, y3, z3, t3); go S_SCAN.
- S_SCAN (leading-zero skip, one bit per cycle):
  - If K[idx]=1: Q=P; if idx==0 go S_DONE, else idx=idx-1 and go S_DBL.
  - Else if idx==0: Q = identity (0, ONE_MONT, ONE_MONT, 0); go S_DONE.
  - Else: idx=idx-1 and stay in S_SCAN.
- S_DBL:
  - Pulse o_pa_start with o_pa_doubling=1, o_pa_initial=0.
  - Operand 1 = operand 2 = Q; go S_DBL_W.
- S_DBL_W:
  - On i_pa_finished: Q = result.
  - If K[idx]=1 go S_ADD, else go S_NEXT.
- S_ADD:
  - Pulse o_pa_start, both op flags 0.
  - Operand 1 = Q, operand 2 = P; go S_ADD_W.
- S_ADD_W:
  - On i_pa_finished: Q = result; go S_NEXT.
- S_NEXT:
  - If idx==0 go S_DONE, else idx=idx-1 and go S_DBL.
- S_DONE:
  - o_x/o_y/o_z/o_t = Q (registered).
  - Pulse o_done exactly one cycle; o_busy falls in the same cycle; go S_IDLE.
- Operand and flag outputs stay stable from the o_pa_start cycle until i_pa_finished.
- o_pa_start never pulses while a point-add operation is outstanding.
- i_pa_finished outside a _W state is ignored.
- Op count for scalar k with MSB at bit m: 1 init + m doubles + (popcount(k)−1) adds.
  - For k=0 the count is 1 init only.
- No arithmetic is done inside this block; index decrement never wraps below 0.

Test Plan:
- Bench uses a behavioural point-add model with 10-cycle latency and logs op type per o_pa_start.
- k=1, P=(9, 20) -> ops {INIT}; o_done after INIT; Q equals the model's initial result; o_busy low after done.
- k=0 -> ops {INIT}; Q=(0, 19, 19, 0); single o_done pulse.
- k=5 (101b) -> op sequence INIT, DBL, DBL, ADD; DBL operands both Q; ADD operand 2 equals the stored P.
- k=2^254 -> 1 INIT + 254 DBL, 0 ADD; k=2^255−1 -> 1 INIT + 254 DBL + 254 ADD; o_done once per run.
- i_start pulsed repeatedly during a k=5 run -> ignored; op count unchanged; then a back-to-back new start right after o_done is accepted.
- i_rst asserted while in S_DBL_W -> next cycle o_busy=0, o_done never pulses, outputs 0; a fresh k=3 run then completes with INIT, DBL, ADD.
